axis_prog_loader: RTL and testbench
===================================

AXIS_PROG_LOADER -- requirements
Module: axis_prog_loader

Interface
REQ-001 The block SHALL have parameter CODE_ADDR_WIDTH, default 10, giving the instruction memory address width.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 prog_TDATA  input  32  program stream data.
REQ-005 prog_TVALID  input  1  program stream valid.
REQ-006 prog_TREADY  output  1  program stream ready.
REQ-007 prog_TLAST  input  1  marks the last word of a load packet.
REQ-008 inst_mem_wr_addr  output  CODE_ADDR_WIDTH  instruction write address.
REQ-009 inst_mem_wr_data  output  8  instruction byte.
REQ-010 inst_mem_wr_en  output  1  instruction write strobe.
REQ-011 imm_wr_addr / imm_wr_data / imm_wr_en  output  4 / 32 / 1  immediates-table write port.
REQ-012 jmp_off_wr_addr / jmp_off_wr_data / jmp_off_wr_en  output  4 / 8 / 1  jump-offset-table write port.
REQ-013 loading  output  1  high while a packet is in progress; the CPU controller holds the CPU in reset on it.
REQ-014 done  output  1  one-cycle pulse on packet completion.
REQ-015 err  output  1  sticky flag: a bad header target was received.

Function
REQ-016 The first word of each packet SHALL be a header:
  - [31:28] = target: 0 = inst, 1 = imm, 2 = jmp, other = invalid.
  - [15:0] = start address, truncated to the target's address width.
REQ-017 FSM states SHALL be HDR, INST_WORD, INST_BYTES, IMM, JMP, DRAIN; reset state is HDR.
REQ-018 HDR: TREADY = 1. On handshake, go to INST_WORD, IMM, JMP or DRAIN per target, and latch the start address into the write pointer.
REQ-019 A header that also has TLAST (zero-length packet) SHALL return to HDR, pulse done next cycle, and perform no writes.
REQ-020 INST_WORD: TREADY = 1. A word accepted at cycle T SHALL be unpacked into four instruction writes:
  - inst_mem_wr_en high in cycles T+1..T+4;
  - data = bytes [7:0], [15:8], [23:16], [31:24] in that order;
  - addresses ptr, ptr+1, ptr+2, ptr+3.
REQ-021 INST_BYTES: TREADY SHALL be 0 in cycles T+1..T+3 and 1 again in T+4, so back-to-back words sustain one word per 4 cycles.
REQ-022 IMM: a word accepted at T SHALL produce imm_wr_en = 1 at T+1 with imm_wr_data = prog_TDATA and imm_wr_addr = ptr; then ptr increments.
REQ-023 JMP: as IMM, but jmp_off_wr_data = prog_TDATA[7:0].
REQ-024 All write pointers SHALL wrap modulo their address space with no error: 2^CODE_ADDR_WIDTH for inst, 16 for imm and jmp.
REQ-025 A data word with TLAST SHALL complete normally (all its writes issued); then FSM → HDR and done pulses in the cycle after the final write.
REQ-026 DRAIN: TREADY = 1. Words are discarded with no writes. err is set in the cycle after the invalid header is accepted. TLAST → HDR with no done pulse.
REQ-027 loading SHALL be 1 from the cycle after header accept until the cycle after the final write, inclusive; it is 0 in HDR.
REQ-028 All write ports and status outputs SHALL be registered; at most one wr_en is high in any cycle.
REQ-029 TREADY SHALL be a function of state only, never of TVALID.
REQ-030 When TVALID = 0 the block SHALL stall with no writes and pointer unchanged. Any number of idle cycles is allowed between words.

Reset
REQ-031 On rst:
  - FSM → HDR; pointers = 0;
  - all wr_en, done, loading, err = 0;
  - prog_TREADY = 0 during reset, 1 (HDR) from the first cycle after reset is released.
REQ-032 Reset mid-packet SHALL abort writes from the next cycle. Writes already issued are not undone. The remainder of the aborted packet is then parsed as a new packet (software's responsibility).

Verification
REQ-033 Inst load: header 0x0000_0010, then word 0xDDCC_BBAA with TLAST → writes AA@0x10, BB@0x11, CC@0x12, DD@0x13 on consecutive cycles; done one cycle after the DD write; loading falls after it.
REQ-034 Wrap and backpressure: inst header 0x0000_03FE, two back-to-back words → addresses 3FE, 3FF, 000, 001, 002, 003, 004, 005; TREADY low exactly 3 of every 4 cycles.
REQ-035 Imm/jmp: header 0x1000_000F, words 0x1234_5678 and 0x9ABC_DEF0 (TLAST) → imm[15] = 0x12345678, imm[0] = 0x9ABCDEF0; header 0x2000_0003, word 0x0000_01FE (TLAST) → jmp[3] = 0xFE.
REQ-036 Invalid target: header 0x7000_0000, 3 words, TLAST on the last → no writes, err = 1 and stays 1, no done; the next valid packet loads correctly.
REQ-037 Reset mid-unpack: assert rst in cycle T+2 after an inst data word → only the byte-0 and byte-1 writes occur; outputs at their reset values; TREADY = 1 one cycle after rst falls.
REQ-038 TVALID gaps: randomly deasserted TVALID during an imm packet → identical table contents and write order as the gap-free run.

Source files
------------

// File: rtl/axis_prog_loader.sv
// -----------------------------------------------------------------------------
// axis_prog_loader
//
// Accepts program-load packets on an AXI-Stream slave and scatters them into
// the CPU's instruction memory (byte-wide), immediates table (32-bit) or
// jump-offset table (8-bit). The first word of each packet is a header that
// selects the target ([31:28]) and the start address ([15:0]). Instruction
// words are unpacked into four byte writes, little byte first, which throttles
// the stream to one word per four cycles. Unknown targets are drained and
// flagged on the sticky err output.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   prog_TDATA/TVALID/TLAST   program stream in
//   prog_TREADY               program stream ready (depends on state only)
//   inst_mem_wr_addr/data/en  instruction memory write port (registered)
//   imm_wr_addr/data/en       immediates table write port (registered)
//   jmp_off_wr_addr/data/en   jump-offset table write port (registered)
//   loading                   packet in progress; CPU is held in reset on it
//   done                      one-cycle pulse after the last write of a packet
//   err                       sticky: a header with an invalid target was seen
// -----------------------------------------------------------------------------
module axis_prog_loader #(
    parameter int CODE_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                prog_TDATA,
    input  logic                       prog_TVALID,
    output logic                       prog_TREADY,
    input  logic                       prog_TLAST,
    output logic [CODE_ADDR_WIDTH-1:0] inst_mem_wr_addr,
    output logic [7:0]                 inst_mem_wr_data,
    output logic                       inst_mem_wr_en,
    output logic [3:0]                 imm_wr_addr,
    output logic [31:0]                imm_wr_data,
    output logic                       imm_wr_en,
    output logic [3:0]                 jmp_off_wr_addr,
    output logic [7:0]                 jmp_off_wr_data,
    output logic                       jmp_off_wr_en,
    output logic                       loading,
    output logic                       done,
    output logic                       err
);

    typedef enum logic [2:0] {
        ST_HDR        = 3'd0,
        ST_INST_WORD  = 3'd1,
        ST_INST_BYTES = 3'd2,
        ST_IMM        = 3'd3,
        ST_JMP        = 3'd4,
        ST_DRAIN      = 3'd5
    } state_t;

    localparam logic [CODE_ADDR_WIDTH-1:0] INST_PTR_ONE = {{(CODE_ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                     state_r;
    logic [CODE_ADDR_WIDTH-1:0] inst_ptr_r;
    logic [3:0]                 tbl_ptr_r;
    logic [31:0]                word_r;
    logic                       last_r;
    logic [1:0]                 byte_idx_r;
    logic                       tready_r;
    logic                       fin_r;
    logic                       done_r;
    logic                       loading_r;
    logic                       err_r;
    logic [CODE_ADDR_WIDTH-1:0] inst_addr_r;
    logic [7:0]                 inst_data_r;
    logic                       inst_en_r;
    logic [3:0]                 imm_addr_r;
    logic [31:0]                imm_data_r;
    logic                       imm_en_r;
    logic [3:0]                 jmp_addr_r;
    logic [7:0]                 jmp_data_r;
    logic                       jmp_en_r;
    logic                       hs_s;

    // Selects one byte of the latched instruction word, byte 0 = bits [7:0].
    function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Handshake: TREADY is a registered copy of "next state is not INST_BYTES",
    // so it is low during reset and never looks at TVALID.
    assign hs_s = prog_TVALID & tready_r;

    // Loader FSM with all write ports and status outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_HDR;
            inst_ptr_r  <= {CODE_ADDR_WIDTH{1'b0}};
            tbl_ptr_r   <= 4'd0;
            word_r      <= 32'd0;
            last_r      <= 1'b0;
            byte_idx_r  <= 2'd0;
            tready_r    <= 1'b0;
            fin_r       <= 1'b0;
            done_r      <= 1'b0;
            loading_r   <= 1'b0;
            err_r       <= 1'b0;
            inst_addr_r <= {CODE_ADDR_WIDTH{1'b0}};
            inst_data_r <= 8'd0;
            inst_en_r   <= 1'b0;
            imm_addr_r  <= 4'd0;
            imm_data_r  <= 32'd0;
            imm_en_r    <= 1'b0;
            jmp_addr_r  <= 4'd0;
            jmp_data_r  <= 8'd0;
            jmp_en_r    <= 1'b0;
        end else begin
            inst_en_r <= 1'b0;
            imm_en_r  <= 1'b0;
            jmp_en_r  <= 1'b0;
            tready_r  <= 1'b1;
            // fin_r marks the cycle of the final write; done follows one cycle later.
            fin_r     <= 1'b0;
            done_r    <= fin_r;
            // loading stays high through the done cycle and drops after it;
            // a header accepted in that same cycle re-asserts it below.
            if (done_r) begin
                loading_r <= 1'b0;
            end else begin
                loading_r <= loading_r;
            end

            case (state_r)
                ST_HDR: begin
                    if (hs_s) begin
                        inst_ptr_r <= prog_TDATA[CODE_ADDR_WIDTH-1:0];
                        tbl_ptr_r  <= prog_TDATA[3:0];
                        if (prog_TDATA[31:28] > 4'd2) begin
                            err_r <= 1'b1;
                        end else begin
                            err_r <= err_r;
                        end
                        if (prog_TLAST) begin
                            // Zero-length packet: no writes; valid targets still report done.
                            state_r <= ST_HDR;
                            if (prog_TDATA[31:28] <= 4'd2) begin
                                done_r <= 1'b1;
                            end else begin
                                done_r <= fin_r;
                            end
                        end else begin
                            loading_r <= 1'b1;
                            case (prog_TDATA[31:28])
                                4'd0:    state_r <= ST_INST_WORD;
                                4'd1:    state_r <= ST_IMM;
                                4'd2:    state_r <= ST_JMP;
                                default: state_r <= ST_DRAIN;
                            endcase
                        end
                    end else begin
                        state_r <= ST_HDR;
                    end
                end

                ST_INST_WORD: begin
                    if (hs_s) begin
                        word_r      <= prog_TDATA;
                        last_r      <= prog_TLAST;
                        inst_en_r   <= 1'b1;
                        inst_addr_r <= inst_ptr_r;
                        inst_data_r <= prog_TDATA[7:0];
                        inst_ptr_r  <= inst_ptr_r + INST_PTR_ONE;
                        byte_idx_r  <= 2'd1;
                        tready_r    <= 1'b0;
                        state_r     <= ST_INST_BYTES;
                    end else begin
                        state_r <= ST_INST_WORD;
                    end
                end

                ST_INST_BYTES: begin
                    inst_en_r   <= 1'b1;
                    inst_addr_r <= inst_ptr_r;
                    inst_data_r <= sel_byte(word_r, byte_idx_r);
                    inst_ptr_r  <= inst_ptr_r + INST_PTR_ONE;
                    byte_idx_r  <= byte_idx_r + 2'd1;
                    if (byte_idx_r == 2'd3) begin
                        if (last_r) begin
                            state_r <= ST_HDR;
                            fin_r   <= 1'b1;
                        end else begin
                            state_r <= ST_INST_WORD;
                        end
                    end else begin
                        tready_r <= 1'b0;
                        state_r  <= ST_INST_BYTES;
                    end
                end

                ST_IMM: begin
                    if (hs_s) begin
                        imm_en_r   <= 1'b1;
                        imm_addr_r <= tbl_ptr_r;
                        imm_data_r <= prog_TDATA;
                        tbl_ptr_r  <= tbl_ptr_r + 4'd1;
                        if (prog_TLAST) begin
                            state_r <= ST_HDR;
                            fin_r   <= 1'b1;
                        end else begin
                            state_r <= ST_IMM;
                        end
                    end else begin
                        state_r <= ST_IMM;
                    end
                end

                ST_JMP: begin
                    if (hs_s) begin
                        jmp_en_r   <= 1'b1;
                        jmp_addr_r <= tbl_ptr_r;
                        jmp_data_r <= prog_TDATA[7:0];
                        tbl_ptr_r  <= tbl_ptr_r + 4'd1;
                        if (prog_TLAST) begin
                            state_r <= ST_HDR;
                            fin_r   <= 1'b1;
                        end else begin
                            state_r <= ST_JMP;
                        end
                    end else begin
                        state_r <= ST_JMP;
                    end
                end

                ST_DRAIN: begin
                    // Discarded packet ends without a done pulse.
                    if (hs_s && prog_TLAST) begin
                        state_r   <= ST_HDR;
                        loading_r <= 1'b0;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end

                default: begin
                    state_r <= ST_HDR;
                end
            endcase
        end
    end

    assign prog_TREADY      = tready_r;
    assign inst_mem_wr_addr = inst_addr_r;
    assign inst_mem_wr_data = inst_data_r;
    assign inst_mem_wr_en   = inst_en_r;
    assign imm_wr_addr      = imm_addr_r;
    assign imm_wr_data      = imm_data_r;
    assign imm_wr_en        = imm_en_r;
    assign jmp_off_wr_addr  = jmp_addr_r;
    assign jmp_off_wr_data  = jmp_data_r;
    assign jmp_off_wr_en    = jmp_en_r;
    assign loading          = loading_r;
    assign done             = done_r;
    assign err              = err_r;

endmodule

// File: tb/tb_axis_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_axis_prog_loader: directed self-checking bench for axis_prog_loader.
// A negedge monitor logs every write, done pulse and loading fall; each test
// task drives packets and compares the log against hand-computed values.
// -----------------------------------------------------------------------------
module tb_axis_prog_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   prog_TDATA;
    logic          prog_TVALID;
    logic          prog_TREADY;
    logic          prog_TLAST;
    logic [AW-1:0] inst_mem_wr_addr;
    logic [7:0]    inst_mem_wr_data;
    logic          inst_mem_wr_en;
    logic [3:0]    imm_wr_addr;
    logic [31:0]   imm_wr_data;
    logic          imm_wr_en;
    logic [3:0]    jmp_off_wr_addr;
    logic [7:0]    jmp_off_wr_data;
    logic          jmp_off_wr_en;
    logic          loading;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    axis_prog_loader #(.CODE_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .prog_TDATA(prog_TDATA), .prog_TVALID(prog_TVALID),
        .prog_TREADY(prog_TREADY), .prog_TLAST(prog_TLAST),
        .inst_mem_wr_addr(inst_mem_wr_addr), .inst_mem_wr_data(inst_mem_wr_data),
        .inst_mem_wr_en(inst_mem_wr_en),
        .imm_wr_addr(imm_wr_addr), .imm_wr_data(imm_wr_data), .imm_wr_en(imm_wr_en),
        .jmp_off_wr_addr(jmp_off_wr_addr), .jmp_off_wr_data(jmp_off_wr_data),
        .jmp_off_wr_en(jmp_off_wr_en),
        .loading(loading), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Monitor state
    int            cyc = 0;
    int            n_inst = 0, n_imm = 0, n_jmp = 0, n_done = 0, n_multi = 0, n_tlow = 0;
    logic [AW-1:0] inst_a [256];
    logic [7:0]    inst_d [256];
    int            inst_c [256];
    logic [3:0]    imm_a  [64];
    logic [31:0]   imm_d  [64];
    logic [3:0]    jmp_a  [64];
    logic [7:0]    jmp_d  [64];
    int            done_c [64];
    int            last_fall = -1;
    logic          prev_loading = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (inst_mem_wr_en && n_inst < 256) begin
            inst_a[n_inst] = inst_mem_wr_addr;
            inst_d[n_inst] = inst_mem_wr_data;
            inst_c[n_inst] = cyc;
            n_inst++;
        end
        if (imm_wr_en && n_imm < 64) begin
            imm_a[n_imm] = imm_wr_addr;
            imm_d[n_imm] = imm_wr_data;
            n_imm++;
        end
        if (jmp_off_wr_en && n_jmp < 64) begin
            jmp_a[n_jmp] = jmp_off_wr_addr;
            jmp_d[n_jmp] = jmp_off_wr_data;
            n_jmp++;
        end
        if ((int'(inst_mem_wr_en) + int'(imm_wr_en) + int'(jmp_off_wr_en)) > 1) n_multi++;
        if (done && n_done < 64) begin
            done_c[n_done] = cyc;
            n_done++;
        end
        if (!loading && prev_loading) last_fall = cyc;
        prev_loading = loading;
        if (!prog_TREADY && !rst) n_tlow++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present one word and hold it until accepted; returns at the negedge after the handshake.
    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        prog_TDATA  = d;
        prog_TLAST  = l;
        prog_TVALID = 1'b1;
        while (!prog_TREADY && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL send_timeout: word %h not accepted within 50 cycles", d);
        end
        @(negedge clk);
        prog_TVALID = 1'b0;
        prog_TLAST  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        prog_TVALID = 1'b0;
        prog_TLAST  = 1'b0;
        prog_TDATA  = 32'd0;
        idle(3);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        rst = 1'b1;
        prog_TVALID = 1'b0;
        prog_TLAST  = 1'b0;
        prog_TDATA  = 32'd0;
        idle(3);
        obs = {prog_TREADY, inst_mem_wr_en, imm_wr_en, jmp_off_wr_en, loading, done, err, 1'b0};
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000000", obs);
        end
        rst = 1'b0;
        idle(1);
        checks++;
        if (prog_TREADY !== 1'b1) begin
            errors++;
            $display("FAIL reset_tready_after: got %b expected 1", prog_TREADY);
        end
    endtask

    task automatic test_inst_load();
        logic [7:0] exp_b [4];
        int b  = n_inst;
        int bd = n_done;
        exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC; exp_b[3] = 8'hDD;
        send(32'h0000_0010, 1'b0);
        idle(3);
        send(32'hDDCC_BBAA, 1'b1);
        idle(8);
        checks++;
        if (n_inst - b !== 4) begin
            errors++;
            $display("FAIL inst_count: got %0d expected 4", n_inst - b);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (inst_a[b+i] !== AW'(32'h10 + i) || inst_d[b+i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL inst_write[%0d]: got %h@%h expected %h@%h", i,
                             inst_d[b+i], inst_a[b+i], exp_b[i], AW'(32'h10 + i));
                end
                if (i > 0) begin
                    checks++;
                    if (inst_c[b+i] !== inst_c[b+i-1] + 1) begin
                        errors++;
                        $display("FAIL inst_consecutive[%0d]: got cycle %0d expected %0d", i,
                                 inst_c[b+i], inst_c[b+i-1] + 1);
                    end
                end
            end
            checks++;
            if (n_done - bd !== 1 || done_c[bd] !== inst_c[b+3] + 1) begin
                errors++;
                $display("FAIL inst_done: got %0d pulses at cycle %0d expected 1 at %0d",
                         n_done - bd, done_c[bd], inst_c[b+3] + 1);
            end
            checks++;
            if (last_fall !== done_c[bd] + 1) begin
                errors++;
                $display("FAIL inst_loading_fall: got cycle %0d expected %0d", last_fall, done_c[bd] + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]    exp_d [8];
        logic [AW-1:0] exp_a [8];
        int b  = n_inst;
        int bt = n_tlow;
        exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000; exp_a[3] = 10'h001;
        exp_a[4] = 10'h002; exp_a[5] = 10'h003; exp_a[6] = 10'h004; exp_a[7] = 10'h005;
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
        exp_d[4] = 8'h55; exp_d[5] = 8'h66; exp_d[6] = 8'h77; exp_d[7] = 8'h88;
        send(32'h0000_03FE, 1'b0);
        send(32'h4433_2211, 1'b0);
        send(32'h8877_6655, 1'b1);
        idle(8);
        checks++;
        if (n_inst - b !== 8) begin
            errors++;
            $display("FAIL wrap_count: got %0d expected 8", n_inst - b);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (inst_a[b+i] !== exp_a[i] || inst_d[b+i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL wrap_write[%0d]: got %h@%h expected %h@%h", i,
                             inst_d[b+i], inst_a[b+i], exp_d[i], exp_a[i]);
                end
            end
            checks++;
            if (inst_c[b+7] - inst_c[b] !== 7) begin
                errors++;
                $display("FAIL wrap_throughput: got span %0d expected 7", inst_c[b+7] - inst_c[b]);
            end
        end
        checks++;
        if (n_tlow - bt !== 6) begin
            errors++;
            $display("FAIL wrap_tready_low: got %0d cycles expected 6", n_tlow - bt);
        end
    endtask

    task automatic test_imm_jmp();
        int bi = n_imm, bj = n_jmp, bn = n_inst, bd = n_done;
        send(32'h1000_000F, 1'b0);
        send(32'h1234_5678, 1'b0);
        send(32'h9ABC_DEF0, 1'b1);
        send(32'h2000_0003, 1'b0);
        send(32'h0000_01FE, 1'b1);
        idle(4);
        checks++;
        if (n_imm - bi !== 2 || imm_a[bi] !== 4'd15 || imm_d[bi] !== 32'h1234_5678 ||
            imm_a[bi+1] !== 4'd0 || imm_d[bi+1] !== 32'h9ABC_DEF0) begin
            errors++;
            $display("FAIL imm_writes: got %0d writes %h@%h %h@%h expected 12345678@f 9abcdef0@0",
                     n_imm - bi, imm_d[bi], imm_a[bi], imm_d[bi+1], imm_a[bi+1]);
        end
        checks++;
        if (n_jmp - bj !== 1 || jmp_a[bj] !== 4'd3 || jmp_d[bj] !== 8'hFE) begin
            errors++;
            $display("FAIL jmp_write: got %0d writes %h@%h expected fe@3", n_jmp - bj, jmp_d[bj], jmp_a[bj]);
        end
        checks++;
        if (n_inst !== bn || n_done - bd !== 2) begin
            errors++;
            $display("FAIL imm_jmp_side: got inst+%0d done+%0d expected inst+0 done+2", n_inst - bn, n_done - bd);
        end
    endtask

    task automatic test_zero_length();
        int bn = n_inst, bi = n_imm, bd = n_done;
        send(32'h1000_0004, 1'b1);
        checks++;
        if (done !== 1'b1 || loading !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_done: got done=%b loading=%b expected done=1 loading=0", done, loading);
        end
        idle(3);
        checks++;
        if (n_inst !== bn || n_imm !== bi || n_done - bd !== 1) begin
            errors++;
            $display("FAIL zero_len_writes: got inst+%0d imm+%0d done+%0d expected 0 0 1",
                     n_inst - bn, n_imm - bi, n_done - bd);
        end
    endtask

    task automatic test_invalid();
        int bn = n_inst, bi = n_imm, bj = n_jmp, bd = n_done;
        send(32'h7000_0000, 1'b0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL invalid_err_set: got %b expected 1", err);
        end
        send(32'h0000_1111, 1'b0);
        send(32'h0000_2222, 1'b0);
        send(32'h0000_3333, 1'b1);
        idle(3);
        checks++;
        if (n_inst !== bn || n_imm !== bi || n_jmp !== bj || n_done !== bd || loading !== 1'b0) begin
            errors++;
            $display("FAIL invalid_drain: got writes %0d/%0d/%0d done+%0d loading=%b expected none, loading=0",
                     n_inst - bn, n_imm - bi, n_jmp - bj, n_done - bd, loading);
        end
        send(32'h1000_0005, 1'b0);
        send(32'hCAFE_F00D, 1'b1);
        idle(4);
        checks++;
        if (n_imm - bi !== 1 || imm_a[bi] !== 4'd5 || imm_d[bi] !== 32'hCAFE_F00D || n_done - bd !== 1) begin
            errors++;
            $display("FAIL invalid_recover: got %0d writes %h@%h done+%0d expected cafef00d@5 done+1",
                     n_imm - bi, imm_d[bi], imm_a[bi], n_done - bd);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL invalid_err_sticky: got %b expected 1", err);
        end
    endtask

    task automatic test_reset_mid_unpack();
        logic [7:0] obs;
        int b;
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err_clear: got %b expected 0", err);
        end
        b = n_inst;
        send(32'h0000_0020, 1'b0);
        send(32'h4433_2211, 1'b0);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        obs = {prog_TREADY, inst_mem_wr_en, imm_wr_en, jmp_off_wr_en, loading, done, err, 1'b0};
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL midreset_outputs: got %b expected 00000000", obs);
        end
        idle(1);
        checks++;
        if (prog_TREADY !== 1'b1) begin
            errors++;
            $display("FAIL midreset_tready: got %b expected 1", prog_TREADY);
        end
        idle(3);
        checks++;
        if (n_inst - b !== 2 || inst_a[b] !== 10'h020 || inst_d[b] !== 8'h11 ||
            inst_a[b+1] !== 10'h021 || inst_d[b+1] !== 8'h22) begin
            errors++;
            $display("FAIL midreset_writes: got %0d writes %h@%h %h@%h expected 11@020 22@021",
                     n_inst - b, inst_d[b], inst_a[b], inst_d[b+1], inst_a[b+1]);
        end
    endtask

    task automatic test_gaps();
        logic [31:0] w [5];
        int bi = n_imm, bd = n_done;
        w[0] = 32'hA000_0001; w[1] = 32'hB000_0002; w[2] = 32'hC000_0003;
        w[3] = 32'hD000_0004; w[4] = 32'hE000_0005;
        send(32'h1000_0008, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle(int'($urandom_range(0, 3)));
            send(w[i], (i == 4) ? 1'b1 : 1'b0);
        end
        idle(4);
        checks++;
        if (n_imm - bi !== 5) begin
            errors++;
            $display("FAIL gaps_count: got %0d expected 5", n_imm - bi);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (imm_a[bi+i] !== 4'(8 + i) || imm_d[bi+i] !== w[i]) begin
                    errors++;
                    $display("FAIL gaps_write[%0d]: got %h@%h expected %h@%h", i,
                             imm_d[bi+i], imm_a[bi+i], w[i], 4'(8 + i));
                end
            end
        end
        checks++;
        if (n_done - bd !== 1) begin
            errors++;
            $display("FAIL gaps_done: got %0d expected 1", n_done - bd);
        end
    endtask

    initial begin
        rst = 1'b1;
        prog_TVALID = 1'b0;
        prog_TLAST  = 1'b0;
        prog_TDATA  = 32'd0;
        test_reset();
        test_inst_load();
        test_back_to_back();
        test_imm_jmp();
        test_zero_length();
        test_invalid();
        test_reset_mid_unpack();
        test_gaps();
        checks++;
        if (n_multi !== 0) begin
            errors++;
            $display("FAIL single_wr_en: got %0d cycles with multiple strobes expected 0", n_multi);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
